// File: rtl/bram_result_reader_pkg.sv
// Shared definitions for the result reader: FSM state encoding (common with
// the multiply datamover), output buffer depth and the read-credit rule.
package bram_result_reader_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

    // A new read may be issued if the buffer plus the in-flight read leave a
    // free slot, or if the buffer is exactly full but is popped this cycle.
    function automatic logic credit_ok(input logic [1:0] occupancy, input logic pop);
        return (occupancy < 2'(FIFO_DEPTH)) || ((occupancy == 2'(FIFO_DEPTH)) && pop);
    endfunction

endpackage

// File: rtl/bram_result_reader_if.sv
// Valid/ready result stream carrying the words drained from Bram1.
interface bram_result_reader_if #(parameter int DWIDTH = 32);

    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/bram_result_reader_sync_fifo2.sv
// Two-entry output buffer. Push and pop may occur in the same cycle, including
// a push into a full buffer that is being popped.
module sync_fifo2
    import bram_result_reader_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);

    logic [1:0][DWIDTH-1:0] mem;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count == 2'(FIFO_DEPTH));
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; reset discards all contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // The credit logic upstream must never push into a full, unpopped buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && full && !pop));

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(pop && empty));

endmodule

// File: rtl/bram_result_reader.sv
// Drains num_cnt result words from Bram1 onto a valid/ready stream. Reads are
// issued against a credit of two slots (buffer entries plus the one read that
// may be in flight), so 1-cycle BRAM latency and backpressure never drop data
// while a held-high m_ready sustains one word per cycle.
module bram_result_reader
    import bram_result_reader_pkg::*;
#(
    parameter int CNT      = 31,
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 12,
    parameter int MEM_SIZE = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_run,
    input  logic [CNT-1:0]        i_num_cnt,
    output logic                  o_idle,
    output logic                  o_run,
    output logic                  o_done,
    output logic [AWIDTH-1:0]     addr_b1,
    output logic                  ce_b1,
    output logic                  we_b1,
    output logic [DWIDTH-1:0]     d0_b1,
    input  logic [DWIDTH-1:0]     q0_b1,
    bram_result_reader_if.master  m_axis
);

    state_t            state;
    state_t            state_nxt;
    logic [CNT-1:0]    num_cnt;
    logic [CNT-1:0]    rd_cnt;
    logic [CNT-1:0]    tx_cnt;
    logic              in_flight;
    logic              pop;
    logic              to_done;
    logic [DWIDTH-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [1:0]        occupancy;

    assign o_idle = (state == S_IDLE);
    assign o_run  = (state == S_RUN);
    assign o_done = (state == S_DONE);

    assign we_b1   = 1'b0;
    assign d0_b1   = '0;
    // Address wraps modulo 2^AWIDTH for runs longer than the memory.
    assign addr_b1 = rd_cnt[AWIDTH-1:0];

    assign pop       = m_axis.m_valid && m_axis.m_ready;
    assign occupancy = fifo_count + {1'b0, in_flight};
    assign ce_b1     = o_run && (rd_cnt < num_cnt) && credit_ok(occupancy, pop);

    // Data is forced to zero while the buffer is empty so idle output is clean.
    assign m_axis.m_valid = !fifo_empty;
    assign m_axis.m_data  = fifo_empty ? '0 : fifo_dout;
    assign m_axis.m_last  = m_axis.m_valid && (tx_cnt == num_cnt - CNT'(1));

    assign to_done = (state != S_DONE) && (state_nxt == S_DONE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state: a zero-length run goes straight to DONE without reads.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_run) state_nxt = (i_num_cnt == '0) ? S_DONE : S_RUN;
            S_RUN:   if (pop && m_axis.m_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Word count is captured only when a start is accepted in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   num_cnt <= '0;
        else if (o_idle && i_run)       num_cnt <= i_num_cnt;
    end

    // Read-issued and words-accepted counters, cleared on entry to DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt <= '0;
            tx_cnt <= '0;
        end else if (to_done) begin
            rd_cnt <= '0;
            tx_cnt <= '0;
        end else begin
            if (ce_b1) rd_cnt <= rd_cnt + CNT'(1);
            if (pop)   tx_cnt <= tx_cnt + CNT'(1);
        end
    end

    // Marks the cycle in which q0_b1 carries the data of last cycle's read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) in_flight <= 1'b0;
        else          in_flight <= ce_b1;
    end

    sync_fifo2 #(.DWIDTH(DWIDTH)) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_flight),
        .pop     (pop),
        .din     (q0_b1),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    a_occ_bound: assert property (@(posedge clk) disable iff (!reset_n)
        occupancy <= 2'(FIFO_DEPTH));

    a_full_consistent: assert property (@(posedge clk) disable iff (!reset_n)
        fifo_full |-> !in_flight || pop);

    a_addr_in_mem: assert property (@(posedge clk) disable iff (!reset_n)
        ce_b1 |-> (32'(addr_b1) < 32'(MEM_SIZE)));

endmodule

// File: tb/tb_bram_result_reader.sv
// Directed bench for bram_result_reader with a registered-read BRAM model.
module tb_bram_result_reader;
    localparam int CNT = 31, DWIDTH = 32, AWIDTH = 12, MEM_SIZE = 4096;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              i_run = 1'b0;
    logic [CNT-1:0]    i_num_cnt = '0;
    logic              o_idle, o_run, o_done, ce_b1, we_b1;
    logic [AWIDTH-1:0] addr_b1;
    logic [DWIDTH-1:0] d0_b1;
    logic [DWIDTH-1:0] q0_b1 = '0;
    logic [DWIDTH-1:0] mem [MEM_SIZE];

    int n_cmp = 0;
    int n_err = 0;

    bram_result_reader_if #(.DWIDTH(DWIDTH)) s_if ();

    bram_result_reader #(.CNT(CNT), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .o_idle(o_idle), .o_run(o_run), .o_done(o_done),
        .addr_b1(addr_b1), .ce_b1(ce_b1), .we_b1(we_b1), .d0_b1(d0_b1), .q0_b1(q0_b1),
        .m_axis(s_if.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ce_b1) q0_b1 <= mem[addr_b1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".idle"}, 32'(o_idle), 32'd1);
        chk({tag, ".run"},  32'(o_run),  32'd0);
        chk({tag, ".done"}, 32'(o_done), 32'd0);
        chk({tag, ".ce"},   32'(ce_b1),  32'd0);
        chk({tag, ".addr"}, 32'(addr_b1), 32'd0);
        chk({tag, ".vld"},  32'(s_if.m_valid), 32'd0);
        chk({tag, ".last"}, 32'(s_if.m_last),  32'd0);
        chk({tag, ".data"}, s_if.m_data, 32'd0);
    endtask

    // mode 0: ready high; 1: ready on odd cycles; 2: ready low until cycle 10.
    // stop_after >= 0 returns once that many handshakes have been seen.
    task automatic run_stream(input string tag, input int num, input int mode, input int stop_after);
        int rd = 0, tx = 0, budget;
        bit done = 0;
        logic [AWIDTH-1:0] last_addr [4];
        budget = num * 3 + 20;
        for (int i = 0; i < 4; i++) last_addr[i] = '0;
        i_num_cnt = CNT'(num);
        i_run = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk);
            #1;
            i_run = 1'b0;
            case (mode)
                1:       s_if.m_ready = cyc[0];
                2:       s_if.m_ready = (cyc >= 10);
                default: s_if.m_ready = 1'b1;
            endcase
            #1;
            if (o_done) begin
                done = 1;
                break;
            end
            if (ce_b1) begin
                chk({tag, ".addr"}, 32'(addr_b1), 32'(rd % MEM_SIZE));
                for (int i = 0; i < 3; i++) last_addr[i] = last_addr[i+1];
                last_addr[3] = addr_b1;
                rd++;
            end
            if (mode == 2 && cyc == 9) chk({tag, ".rd_held"}, 32'(rd), 32'd2);
            if (s_if.m_valid) begin
                chk({tag, ".data"}, s_if.m_data, mem[tx % MEM_SIZE]);
                chk({tag, ".last"}, 32'(s_if.m_last), 32'(tx == num - 1));
                if (mode == 2 && !s_if.m_ready) chk({tag, ".hold"}, s_if.m_data, 32'h11);
                if (s_if.m_ready) tx++;
            end
            if (stop_after >= 0 && tx == stop_after) return;
        end
        chk({tag, ".done_seen"}, 32'(done), 32'd1);
        chk({tag, ".beats"}, 32'(tx), 32'(num));
        chk({tag, ".reads"}, 32'(rd), 32'(num));
        if (num >= 4098) begin
            chk({tag, ".tail0"}, 32'(last_addr[0]), 32'd4094);
            chk({tag, ".tail1"}, 32'(last_addr[1]), 32'd4095);
            chk({tag, ".tail2"}, 32'(last_addr[2]), 32'd0);
            chk({tag, ".tail3"}, 32'(last_addr[3]), 32'd1);
        end
        tick();
        chk({tag, ".idle_after"}, 32'(o_idle), 32'd1);
    endtask

    // Expected per-cycle values for the basic 4-word run, cycles T+1..T+8.
    logic [7:0]  e_ce   = 8'b0000_1111;
    logic [7:0]  e_vld  = 8'b0011_1100;
    logic [7:0]  e_last = 8'b0010_0000;
    logic [7:0]  e_done = 8'b0100_0000;
    logic [7:0]  e_idle = 8'b1000_0000;
    logic [7:0]  e_run  = 8'b0011_1111;
    logic [31:0] e_data [8] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h0};

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 32'hC0DE_0000 ^ i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        s_if.m_ready = 1'b1;

        #12;
        chk_reset_outs("rst");
        chk("rst.we", 32'(we_b1), 32'd0);
        chk("rst.d0", d0_b1, 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: basic cycle-accurate run.
        i_num_cnt = CNT'(4);
        i_run = 1'b1;
        chk("t1.idle_T", 32'(o_idle), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            i_run = 1'b0;
            chk($sformatf("t1.ce%0d", k),   32'(ce_b1),  32'(e_ce[k-1]));
            chk($sformatf("t1.vld%0d", k),  32'(s_if.m_valid), 32'(e_vld[k-1]));
            chk($sformatf("t1.last%0d", k), 32'(s_if.m_last),  32'(e_last[k-1]));
            chk($sformatf("t1.done%0d", k), 32'(o_done), 32'(e_done[k-1]));
            chk($sformatf("t1.idle%0d", k), 32'(o_idle), 32'(e_idle[k-1]));
            chk($sformatf("t1.run%0d", k),  32'(o_run),  32'(e_run[k-1]));
            chk($sformatf("t1.data%0d", k), s_if.m_data, e_data[k-1]);
            if (e_ce[k-1]) chk($sformatf("t1.addr%0d", k), 32'(addr_b1), 32'(k - 1));
        end

        // 2: backpressure until T+10.
        tick();
        run_stream("t2", 4, 2, -1);

        // 3: toggling ready.
        run_stream("t3", 6, 1, -1);

        // 4: zero-length run.
        s_if.m_ready = 1'b1;
        i_num_cnt = '0;
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
        chk("t4.done", 32'(o_done), 32'd1);
        chk("t4.ce",   32'(ce_b1),  32'd0);
        chk("t4.vld",  32'(s_if.m_valid), 32'd0);
        chk("t4.run",  32'(o_run),  32'd0);
        tick();
        chk("t4.idle", 32'(o_idle), 32'd1);
        chk("t4.vld2", 32'(s_if.m_valid), 32'd0);

        // 5: reset after two words, then a fresh 3-word run.
        run_stream("t5a", 8, 0, 2);
        reset_n = 1'b0;
        #1;
        chk_reset_outs("t5rst");
        tick();
        chk_reset_outs("t5rst2");
        reset_n = 1'b1;
        tick();
        run_stream("t5b", 3, 0, -1);

        // 6: address wrap.
        run_stream("t6", 4098, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
